// File: rtl/tt_um_asiclab_nibble_div.sv
// Iterative 4-bit restoring divider on the Tiny Tapeout pin frame.
// A start edge on uio_in[0] launches the operation. Q/R appear on uo_out and busy/done/dbz on uio_out.
module tt_um_asiclab_nibble_div #(
  parameter int unsigned WIDTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);

  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_start_q;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_p;
  logic [CW-1:0]    r_cnt;
  logic [7:0]       r_uo;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic             w_accept;
  logic [WIDTH:0]   w_p_shift;
  logic             w_ge;
  logic [WIDTH:0]   w_p_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_unused_ok;

  assign w_accept  = uio_in[0] & ~r_start_q & (r_state == S_IDLE);

  // One restoring step: r_a is shifted left each iteration, so its MSB is A[3-counter].
  assign w_p_shift = {r_p[WIDTH-1:0], r_a[WIDTH-1]};
  assign w_ge      = (w_p_shift >= {1'b0, r_b});
  assign w_p_next  = w_ge ? (w_p_shift - {1'b0, r_b}) : w_p_shift;
  assign w_q_next  = {r_q[WIDTH-2:0], w_ge};

  assign uo_out      = r_uo;
  assign uio_out     = {4'b0000, r_dbz, r_done, r_busy, 1'b0};
  assign uio_oe      = 8'b0000_1110;
  assign w_unused_ok = ^{ena, uio_in[7:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_q       <= '0;
      r_p       <= '0;
      r_cnt     <= '0;
      r_uo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      r_start_q <= uio_in[0];
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (ui_in[3:0] == '0) begin
              // Divide by zero: all-ones quotient and the dividend as the remainder, with no RUN cycles.
              r_uo    <= {4'hF, ui_in[7:4]};
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_a     <= ui_in[7:4];
              r_b     <= ui_in[3:0];
              r_p     <= '0;
              r_q     <= '0;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_dbz   <= 1'b0;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_p   <= w_p_next;
          r_q   <= w_q_next;
          r_a   <= r_a << 1;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_uo    <= {w_q_next, w_p_next[WIDTH-1:0]};
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_asiclab_nibble_div.sv
// Directed self-checking bench for the nibble divider.
module tb_tt_um_asiclab_nibble_div;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;

  int n_checks = 0;
  int n_fail   = 0;

  tt_um_asiclab_nibble_div dut (
    .clk    (clk),
    .reset  (reset),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle, then wait (bounded) for done. lat counts edges after the accepting edge.
  task automatic run_div(input logic [3:0] a, input logic [3:0] b, output int lat,
                         output int busy_cyc, output logic [7:0] res, output logic dbz);
    ui_in     = {a, b};
    uio_in[0] = 1'b1;
    step();
    uio_in[0] = 1'b0;
    lat       = 0;
    busy_cyc  = 0;
    while (uio_out[2] !== 1'b1 && lat < 16) begin
      if (uio_out[1] === 1'b1) busy_cyc++;
      step();
      lat++;
    end
    res = uo_out;
    dbz = uio_out[3];
    if (uio_out[2] !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout a=%0d b=%0d: done=%b, required 1 within 16 cycles", a, b, uio_out[2]);
    end
    step();
  endtask

  task automatic test_reset();
    int lat;
    reset  = 1'b1;
    ena    = 1'b1;
    ui_in  = {4'd8, 4'd2};
    uio_in = 8'h01;
    #12;
    n_checks++;
    if (uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_uo_out: got %h, required 00", uo_out); end
    n_checks++;
    if (uio_out !== 8'h00) begin n_fail++; $display("FAIL reset_uio_out: got %h, required 00", uio_out); end
    n_checks++;
    if (uio_oe !== 8'h0E) begin n_fail++; $display("FAIL reset_uio_oe: got %h, required 0E", uio_oe); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    n_checks++;
    if (uio_out[1] !== 1'b1) begin n_fail++; $display("FAIL start_across_reset_busy: got %b, required 1", uio_out[1]); end
    uio_in[0] = 1'b0;
    lat = 0;
    while (uio_out[2] !== 1'b1 && lat < 16) begin step(); lat++; end
    n_checks++;
    if (uo_out !== 8'h40) begin n_fail++; $display("FAIL start_across_reset_result: got %h, required 40", uo_out); end
    step();
  endtask

  task automatic test_basic();
    int lat, bc;
    logic [7:0] res;
    logic dbz;
    run_div(4'd13, 4'd3, lat, bc, res, dbz);
    n_checks++;
    if (res !== 8'h41) begin n_fail++; $display("FAIL basic_result: got %h, required 41", res); end
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d, required 4", lat); end
    n_checks++;
    if (bc !== 4) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d, required 4", bc); end
    n_checks++;
    if (dbz !== 1'b0) begin n_fail++; $display("FAIL basic_dbz: got %b, required 0", dbz); end
    n_checks++;
    if (uio_out[2] !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b, required 0", uio_out[2]); end
    n_checks++;
    if (uo_out !== 8'h41) begin n_fail++; $display("FAIL result_hold: got %h, required 41", uo_out); end
  endtask

  task automatic test_patterns();
    logic [3:0] av [3] = '{4'd15, 4'd0, 4'd4};
    logic [3:0] bv [3] = '{4'd1, 4'd5, 4'd9};
    logic [7:0] ev [3] = '{8'hF0, 8'h00, 8'h04};
    int lat, bc;
    logic [7:0] res;
    logic dbz;
    for (int i = 0; i < 3; i++) begin
      run_div(av[i], bv[i], lat, bc, res, dbz);
      n_checks++;
      if (res !== ev[i] || lat !== 4)
        begin n_fail++; $display("FAIL pattern_%0d: got %h lat %0d, required %h lat 4", i, res, lat, ev[i]); end
    end
  endtask

  task automatic test_dbz();
    int lat, bc;
    logic [7:0] res;
    logic dbz;
    run_div(4'd7, 4'd0, lat, bc, res, dbz);
    n_checks++;
    if (res !== 8'hF7 || dbz !== 1'b1)
      begin n_fail++; $display("FAIL dbz_result: got %h dbz %b, required F7 dbz 1", res, dbz); end
    n_checks++;
    if (lat !== 0 || bc !== 0)
      begin n_fail++; $display("FAIL dbz_timing: got lat %0d busy %0d, required 0 0", lat, bc); end
    n_checks++;
    if (uio_out[3] !== 1'b1 || uo_out !== 8'hF7)
      begin n_fail++; $display("FAIL dbz_hold: got %h dbz %b, required F7 dbz 1", uo_out, uio_out[3]); end
    run_div(4'd6, 4'd2, lat, bc, res, dbz);
    n_checks++;
    if (res !== 8'h30 || dbz !== 1'b0)
      begin n_fail++; $display("FAIL dbz_clear: got %h dbz %b, required 30 dbz 0", res, dbz); end
  endtask

  task automatic test_hold_start();
    int dones = 0;
    ui_in     = {4'd9, 4'd2};
    uio_in[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 1) ui_in = 8'hFF;
      if (uio_out[2] === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 1 || uo_out !== 8'h41)
      begin n_fail++; $display("FAIL hold_start: got %0d dones %h, required 1 dones 41", dones, uo_out); end
    uio_in[0] = 1'b0;
    step();
  endtask

  task automatic test_toggle_during_run();
    int dones = 0;
    ui_in = {4'd9, 4'd2};
    for (int i = 0; i < 14; i++) begin
      uio_in[0] = (i == 0 || i == 2 || i == 5);
      step();
      if (i == 0) ui_in = 8'hFF;
      if (uio_out[2] === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 1 || uo_out !== 8'h41)
      begin n_fail++; $display("FAIL toggle_during_run: got %0d dones %h, required 1 dones 41", dones, uo_out); end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    logic [7:0] res;
    logic dbz;
    ui_in     = {4'd14, 4'd3};
    uio_in[0] = 1'b1;
    step();
    uio_in[0] = 1'b0;
    step();
    reset = 1'b1;
    #1;
    n_checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00)
      begin n_fail++; $display("FAIL reset_mid: got uo %h uio %h, required 00 00", uo_out, uio_out); end
    step();
    step();
    reset = 1'b0;
    step();
    run_div(4'd14, 4'd3, lat, bc, res, dbz);
    n_checks++;
    if (res !== 8'h42 || lat !== 4)
      begin n_fail++; $display("FAIL after_reset: got %h lat %0d, required 42 lat 4", res, lat); end
  endtask

  task automatic test_sweep();
    int lat, bc;
    logic [7:0] res, exp_res;
    logic dbz;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_div(4'(a), 4'(b), lat, bc, res, dbz);
        exp_res = (b == 0) ? {4'hF, 4'(a)} : {4'(a / b), 4'(a % b)};
        n_checks++;
        if (res !== exp_res || dbz !== (b == 0))
          begin n_fail++; $display("FAIL sweep a=%0d b=%0d: got %h dbz %b, required %h dbz %b", a, b, res, dbz, exp_res, b == 0); end
        n_checks++;
        if (uio_oe !== 8'h0E) begin n_fail++; $display("FAIL sweep_uio_oe: got %h, required 0E", uio_oe); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_dbz();
    test_hold_start();
    test_toggle_during_run();
    test_reset_mid();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_asiclab_nibble_div.md
Name: tt_um_asiclab_nibble_div

Overview:
- Iterative restoring divider for 4-bit operands. It is the subtract-side counterpart of the team's nibble adder tile, on the same Tiny Tapeout pin frame.
- Dividend is ui_in[7:4] and divisor is ui_in[3:0].
- A start edge on uio_in[0] launches a 4-iteration shift/subtract sequence.
- Quotient and remainder are returned on uo_out, with busy/done/divide-by-zero status on uio_out.

Parameters:
- WIDTH, 4, operand width. Only 4 is supported because the pin map is fixed.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset (internally reset = ~rst_n at the tile boundary)
- ui_in  input  8  [7:4] dividend A, [3:0] divisor B; sampled on the accepting edge only
- uo_out  output  8  [7:4] quotient Q, [3:0] remainder R; registered
- uio_in  input  8  [0] start (level input, rising edge detected internally); [7:1] unused
- uio_out  output  8  [1] busy, [2] done, [3] dbz (divide by zero); [0], [7:4] tied 0
- uio_oe  output  8  constant 8'b0000_1110
- ena  input  1  unused

Behaviour:
- Reset (async): state=IDLE, uo_out=0, busy=0, done=0, dbz=0, start_q=0, counter=0, partial remainder=0.
- Start detect: start_q <= uio_in[0] every cycle. Accept = uio_in[0] & ~start_q & (state==IDLE).
  - Start held high across reset release triggers one operation on the first clock.
  - Start held high continuously triggers exactly one operation.
- States: IDLE, RUN, DONE.
- IDLE, edge E0 with accept and B!=0: latch A and B, clear partial remainder P (5 bits), counter=0, busy=1, dbz=0, state->RUN.
- IDLE, edge E0 with accept and B==0: uo_out={4'hF, A}, dbz=1, done=1, busy=0, state->DONE. No RUN cycles.
- RUN, each edge E1..E4 performs one iteration:
  - Shift in the dividend MSB first: P' = {P[3:0], A[3-counter]}.
  - If P' >= {1'b0,B}: P = P' - B and quotient bit = 1; else P = P' and quotient bit = 0.
  - Quotient bits are shifted in MSB first.
  - Arithmetic is 5-bit unsigned; P < B always holds after each step, so there is no overflow.
- At E4 (counter==3): uo_out={Q, P[3:0]}, busy=0, done=1, state->DONE.
- DONE: one cycle only. Next edge: done=0, state->IDLE.
  - uo_out and dbz hold until the next accepted start.
  - dbz is cleared on the next accept.
- Latency: results visible after E4, i.e. 4 cycles after the accepting edge (1 cycle for B==0). Done is a 1-cycle pulse.
- Start edges while in RUN or DONE are ignored and not queued. start_q still tracks the input, so an edge that occurs while busy is consumed.
- Operand changes on ui_in during RUN have no effect (latched copies are used).
- Back-to-back: a new accept is possible on the edge after DONE (in IDLE), provided start has fallen and risen again.
- Reset mid-operation: immediate return to reset values; no result is produced.
- uo_out changes only on result write (E4 or the B==0 accept) and on reset.

Test Plan:
- A=13, B=3; start pulse -> busy=1 for 4 cycles, then done pulse with uo_out=8'h41 (Q=4, R=1), dbz=0.
- A=15, B=1 -> uo_out=8'hF0. Then A=0, B=5 -> uo_out=8'h00. Then A=4, B=9 -> uo_out=8'h04. Each run is 4-cycle latency.
- A=7, B=0 -> on the next cycle done=1, dbz=1, uo_out=8'hF7, busy never asserted. Following normal division (A=6, B=2) -> dbz=0, uo_out=8'h30.
- Hold start high for 20 cycles with A=9, B=2 -> exactly one done pulse, uo_out=8'h41. Extra start toggles issued during RUN, and ui_in changed to 8'hFF during RUN -> no effect on the result and no second done.
- Assert reset at the 2nd RUN cycle of A=14, B=3 -> uo_out=0 and busy/done/dbz=0 immediately. A fresh start after release -> uo_out=8'h42.
- Sweep of all 256 (A,B) pairs with start pulses -> Q and R match A/B and A%B. B==0 yields Q=F, R=A, dbz=1. uio_oe==8'h0E throughout.
